// File: rtl/fb_blit_writer.sv
// fb_blit_writer: drawing engine that turns fill / glyph / clear commands into
// one framebuffer pixel write per clock, in raster order, clipped to the panel.
// A command is taken in IDLE, its extents and start address are resolved in a
// single SETUP cycle, pixels stream out in WRITE, and DONE pulses for one cycle.
module fb_blit_writer #(
    parameter int H_DISP = 480,
    parameter int V_DISP = 272,
    parameter int ADDR_W = 17
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [10:0]       cmd_x,
    input  logic [10:0]       cmd_y,
    input  logic [10:0]       cmd_w,
    input  logic [10:0]       cmd_h,
    input  logic [23:0]       cmd_fg,
    input  logic [23:0]       cmd_bg,
    input  logic [127:0]      cmd_glyph,
    input  logic              cmd_transp,
    output logic              busy,
    output logic              done,
    output logic              fb_ena,
    output logic              fb_wea,
    output logic [ADDR_W-1:0] fb_addra,
    output logic [23:0]       fb_dina
);

    localparam logic [10:0]       H_W      = 11'(H_DISP);
    localparam logic [10:0]       V_W      = 11'(V_DISP);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_DISP);

    localparam logic [1:0] OP_FILL  = 2'd0;
    localparam logic [1:0] OP_GLYPH = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Visible extent of a span starting at org with length ext on an axis of
    // size limit; zero when the span starts off-panel.
    function automatic logic [10:0] clip_extent(input logic [10:0] org,
                                                input logic [10:0] ext,
                                                input logic [10:0] limit);
        logic [10:0] room;
        room = limit - org;
        if (org >= limit) begin
            clip_extent = 11'd0;
        end else if (ext < room) begin
            clip_extent = ext;
        end else begin
            clip_extent = room;
        end
    endfunction

    state_t              state_r;
    state_t              state_nx_s;

    // Captured command
    logic [1:0]          op_r;
    logic [10:0]         x_r;
    logic [10:0]         y_r;
    logic [10:0]         w_r;
    logic [10:0]         h_r;
    logic [23:0]         fg_r;
    logic [23:0]         bg_r;
    logic [127:0]        glyph_r;
    logic                transp_r;

    // Resolved geometry and raster cursor
    logic [10:0]         org_x_s;
    logic [10:0]         org_y_s;
    logic [10:0]         ext_w_s;
    logic [10:0]         ext_h_s;
    logic [10:0]         clip_w_s;
    logic [10:0]         clip_h_s;
    logic [ADDR_W-1:0]   start_addr_s;
    logic [10:0]         w_eff_r;
    logic [10:0]         h_eff_r;
    logic [10:0]         col_r;
    logic [10:0]         row_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   base_r;

    // Next pixel selection
    logic                load_s;
    logic [10:0]         nx_col_s;
    logic [10:0]         nx_row_s;
    logic [ADDR_W-1:0]   nx_addr_s;
    logic [ADDR_W-1:0]   nx_base_s;
    logic [6:0]          glyph_idx_s;
    logic                glyph_bit_s;
    logic [23:0]         pix_data_s;
    logic                pix_en_s;

    // Output registers
    logic                fb_ena_r;
    logic                fb_wea_r;
    logic [ADDR_W-1:0]   fb_addra_r;
    logic [23:0]         fb_dina_r;
    logic                busy_r;
    logic                done_r;

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = busy_r;
    assign done      = done_r;
    assign fb_ena    = fb_ena_r;
    assign fb_wea    = fb_wea_r;
    assign fb_addra  = fb_addra_r;
    assign fb_dina   = fb_dina_r;

    // Per-op origin and unclipped size, then clipping and the start address.
    always_comb begin
        org_x_s = x_r;
        org_y_s = y_r;
        ext_w_s = w_r;
        ext_h_s = h_r;
        case (op_r)
            OP_FILL: begin
                ext_w_s = w_r;
                ext_h_s = h_r;
            end
            OP_GLYPH: begin
                ext_w_s = 11'd8;
                ext_h_s = 11'd16;
            end
            OP_CLEAR: begin
                org_x_s = 11'd0;
                org_y_s = 11'd0;
                ext_w_s = H_W;
                ext_h_s = V_W;
            end
            default: begin
                ext_w_s = 11'd0;
                ext_h_s = 11'd0;
            end
        endcase
        clip_w_s     = clip_extent(org_x_s, ext_w_s, H_W);
        clip_h_s     = clip_extent(org_y_s, ext_h_s, V_W);
        start_addr_s = ADDR_W'(org_y_s) * ROW_STEP + ADDR_W'(org_x_s);
    end

    // Next-state logic and raster cursor advance (x fastest, rows by +H_DISP).
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        nx_col_s   = col_r;
        nx_row_s   = row_r;
        nx_addr_s  = addr_r;
        nx_base_s  = base_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nx_s = ST_SETUP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if ((clip_w_s == 11'd0) || (clip_h_s == 11'd0)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_WRITE;
                    load_s     = 1'b1;
                    nx_col_s   = 11'd0;
                    nx_row_s   = 11'd0;
                    nx_addr_s  = start_addr_s;
                    nx_base_s  = start_addr_s;
                end
            end
            ST_WRITE: begin
                if (col_r == (w_eff_r - 11'd1)) begin
                    if (row_r == (h_eff_r - 11'd1)) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_WRITE;
                        load_s     = 1'b1;
                        nx_col_s   = 11'd0;
                        nx_row_s   = row_r + 11'd1;
                        nx_base_s  = base_r + ROW_STEP;
                        nx_addr_s  = base_r + ROW_STEP;
                    end
                end else begin
                    state_nx_s = ST_WRITE;
                    load_s     = 1'b1;
                    nx_col_s   = col_r + 11'd1;
                    nx_addr_s  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Colour and write-enable for the pixel about to be presented.
    always_comb begin
        glyph_idx_s = {nx_row_s[3:0], nx_col_s[2:0]};
        glyph_bit_s = glyph_r[7'd127 - glyph_idx_s];
        case (op_r)
            OP_GLYPH: pix_data_s = glyph_bit_s ? fg_r : bg_r;
            OP_CLEAR: pix_data_s = bg_r;
            default:  pix_data_s = fg_r;
        endcase
        if ((op_r == OP_GLYPH) && transp_r && !glyph_bit_s) begin
            pix_en_s = 1'b0;
        end else begin
            pix_en_s = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Capture all command fields on the accepting edge.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            op_r     <= 2'd0;
            x_r      <= 11'd0;
            y_r      <= 11'd0;
            w_r      <= 11'd0;
            h_r      <= 11'd0;
            fg_r     <= 24'd0;
            bg_r     <= 24'd0;
            glyph_r  <= 128'd0;
            transp_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && cmd_valid) begin
            op_r     <= cmd_op;
            x_r      <= cmd_x;
            y_r      <= cmd_y;
            w_r      <= cmd_w;
            h_r      <= cmd_h;
            fg_r     <= cmd_fg;
            bg_r     <= cmd_bg;
            glyph_r  <= cmd_glyph;
            transp_r <= cmd_transp;
        end
    end

    // Clipped extents latched in SETUP; raster cursor follows the next-pixel logic.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            w_eff_r <= 11'd0;
            h_eff_r <= 11'd0;
            col_r   <= 11'd0;
            row_r   <= 11'd0;
            addr_r  <= '0;
            base_r  <= '0;
        end else begin
            if (state_r == ST_SETUP) begin
                w_eff_r <= clip_w_s;
                h_eff_r <= clip_h_s;
            end
            col_r  <= nx_col_s;
            row_r  <= nx_row_s;
            addr_r <= nx_addr_s;
            base_r <= nx_base_s;
        end
    end

    // Registered framebuffer port and status; address/data hold between writes.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            fb_ena_r   <= 1'b0;
            fb_wea_r   <= 1'b0;
            fb_addra_r <= '0;
            fb_dina_r  <= 24'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            fb_ena_r <= load_s && pix_en_s;
            fb_wea_r <= load_s && pix_en_s;
            if (load_s && pix_en_s) begin
                fb_addra_r <= nx_addr_s;
                fb_dina_r  <= pix_data_s;
            end
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= (state_nx_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_fb_blit_writer.sv
// Scoreboard bench for fb_blit_writer: the stimulus pushes hand-derived
// write/done events (with the cycle they must appear in) into a queue, and a
// negedge monitor pops and compares whenever a DUT shows fb_ena or done.
// A second, small-panel instance (20x10) carries the full-screen clear.
module tb_fb_blit_writer;

    typedef struct {
        bit          is_done;
        int          addr;
        logic [23:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_on = 1'b0;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;

    // Main instance (480x272)
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [10:0]  cmd_x = 11'd0, cmd_y = 11'd0, cmd_w = 11'd0, cmd_h = 11'd0;
    logic [23:0]  cmd_fg = 24'd0, cmd_bg = 24'd0;
    logic [127:0] cmd_glyph = 128'd0;
    logic         cmd_transp = 1'b0;
    logic         busy, done, fb_ena, fb_wea;
    logic [16:0]  fb_addra;
    logic [23:0]  fb_dina;

    // Small instance (20x10)
    logic         s_cmd_valid = 1'b0;
    logic         s_cmd_ready;
    logic [1:0]   s_cmd_op = 2'd0;
    logic [10:0]  s_cmd_x = 11'd0, s_cmd_y = 11'd0, s_cmd_w = 11'd0, s_cmd_h = 11'd0;
    logic [23:0]  s_cmd_fg = 24'd0, s_cmd_bg = 24'd0;
    logic         s_busy, s_done, s_fb_ena, s_fb_wea;
    logic [7:0]   s_fb_addra;
    logic [23:0]  s_fb_dina;

    fb_blit_writer #(.H_DISP(480), .V_DISP(272), .ADDR_W(17)) dut (
        .sys_clk(clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_fg(cmd_fg), .cmd_bg(cmd_bg), .cmd_glyph(cmd_glyph), .cmd_transp(cmd_transp),
        .busy(busy), .done(done), .fb_ena(fb_ena), .fb_wea(fb_wea),
        .fb_addra(fb_addra), .fb_dina(fb_dina)
    );

    fb_blit_writer #(.H_DISP(20), .V_DISP(10), .ADDR_W(8)) dut_s (
        .sys_clk(clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(s_cmd_op),
        .cmd_x(s_cmd_x), .cmd_y(s_cmd_y), .cmd_w(s_cmd_w), .cmd_h(s_cmd_h),
        .cmd_fg(s_cmd_fg), .cmd_bg(s_cmd_bg), .cmd_glyph(128'd0), .cmd_transp(1'b0),
        .busy(s_busy), .done(s_done), .fb_ena(s_fb_ena), .fb_wea(s_fb_wea),
        .fb_addra(s_fb_addra), .fb_dina(s_fb_dina)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, got, req, cyc);
        end
    endtask

    task automatic push(input int d, input bit is_done, input int addr,
                        input logic [23:0] data, input int at);
        exp_t e;
        e.is_done = is_done; e.addr = addr; e.data = data; e.cyc = at;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_evt(input int d, input bit is_done, input int addr, input logic [23:0] data);
        exp_t e;
        checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL dut%0d_unexpected: got done=%0d addr=%0d data=%06h at cyc %0d, required no event",
                     d, is_done, addr, data, cyc);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.is_done != is_done || e.cyc != cyc ||
                (!is_done && (e.addr != addr || e.data != data))) begin
                errors++;
                $display("FAIL dut%0d_event: got done=%0d addr=%0d data=%06h cyc=%0d, required done=%0d addr=%0d data=%06h cyc=%0d",
                         d, is_done, addr, data, cyc, e.is_done, e.addr, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: compare every presented write / done against the scoreboard.
    always @(negedge clk) begin
        if (mon_on) begin
            if (fb_ena)   mon_evt(0, 1'b0, int'(fb_addra), fb_dina);
            if (done)     mon_evt(0, 1'b1, 0, 24'd0);
            if (s_fb_ena) mon_evt(1, 1'b0, int'(s_fb_addra), s_fb_dina);
            if (s_done)   mon_evt(1, 1'b1, 0, 24'd0);
            if (fb_ena != fb_wea || s_fb_ena != s_fb_wea) begin
                errors++;
                $display("FAIL ena_wea: got ena=%0d/%0d wea=%0d/%0d, required equal", fb_ena, s_fb_ena, fb_wea, s_fb_wea);
            end
            if (busy == cmd_ready || s_busy == s_cmd_ready) begin
                errors++;
                $display("FAIL busy_ready: got busy=%0d ready=%0d, required busy = !ready", busy, cmd_ready);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input int x, input int y, input int w, input int h,
                         input logic [23:0] fg, input logic [23:0] bg, input logic [127:0] g,
                         input bit tr, output int acc);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        chk("issue_ready", int'(cmd_ready), 1);
        cmd_op = op; cmd_x = 11'(x); cmd_y = 11'(y); cmd_w = 11'(w); cmd_h = 11'(h);
        cmd_fg = fg; cmd_bg = bg; cmd_glyph = g; cmd_transp = tr; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !cmd_ready || !s_cmd_ready) && n < 3000) begin
            @(negedge clk); n++;
        end
        chk("drain_timeout", (n >= 3000) ? 1 : 0, 0);
    endtask

    initial begin
        int acc, acc2, n;
        logic [127:0] g80, ga0;
        g80 = {8'h80, 120'd0};
        ga0 = {8'hA0, 120'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ena", int'(fb_ena), 0);
        chk("rst_addr", int'(fb_addra), 0);
        chk("rst_data", int'(fb_dina), 0);
        mon_on = 1'b1;

        // Fill 3x2 at (10,2)
        issue(2'd0, 10, 2, 3, 2, 24'hFF0000, 24'h0, 128'd0, 1'b0, acc);
        push(0, 0, 970,  24'hFF0000, acc + 1);
        push(0, 0, 971,  24'hFF0000, acc + 2);
        push(0, 0, 972,  24'hFF0000, acc + 3);
        push(0, 0, 1450, 24'hFF0000, acc + 4);
        push(0, 0, 1451, 24'hFF0000, acc + 5);
        push(0, 0, 1452, 24'hFF0000, acc + 6);
        push(0, 1, 0, 24'h0, acc + 7);
        @(negedge clk);
        chk("fill_ready_low", int'(cmd_ready), 0);
        drain();

        // Corner clip: only (478,271),(479,271) survive
        issue(2'd0, 478, 271, 5, 5, 24'h123456, 24'h0, 128'd0, 1'b0, acc);
        push(0, 0, 130558, 24'h123456, acc + 1);
        push(0, 0, 130559, 24'h123456, acc + 2);
        push(0, 1, 0, 24'h0, acc + 3);
        drain();

        // Off-panel origin, zero width, no-op: done right after SETUP
        issue(2'd0, 480, 0, 3, 3, 24'h111111, 24'h0, 128'd0, 1'b0, acc);
        push(0, 1, 0, 24'h0, acc + 1);
        drain();
        issue(2'd0, 5, 5, 0, 3, 24'h222222, 24'h0, 128'd0, 1'b0, acc);
        push(0, 1, 0, 24'h0, acc + 1);
        drain();
        issue(2'd3, 5, 5, 4, 4, 24'h333333, 24'h0, 128'd0, 1'b0, acc);
        push(0, 1, 0, 24'h0, acc + 1);
        drain();

        // Opaque glyph at origin: 128 writes, only top-left is foreground
        issue(2'd1, 0, 0, 0, 0, 24'hFFFFFF, 24'h000000, g80, 1'b0, acc);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++)
                push(0, 0, r * 480 + c, (r == 0 && c == 0) ? 24'hFFFFFF : 24'h000000, acc + 1 + r * 8 + c);
        push(0, 1, 0, 24'h0, acc + 129);
        drain();

        // Transparent glyph: one enabled write, done still after 128 cycles
        issue(2'd1, 0, 0, 0, 0, 24'hFFFFFF, 24'h000000, g80, 1'b1, acc);
        push(0, 0, 0, 24'hFFFFFF, acc + 1);
        push(0, 1, 0, 24'h0, acc + 129);
        drain();

        // Glyph clipped on right (4 cols) and bottom (12 rows)
        issue(2'd1, 476, 260, 0, 0, 24'h0000FF, 24'h111111, ga0, 1'b0, acc);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 4; c++)
                push(0, 0, (260 + r) * 480 + 476 + c,
                     (r == 0 && (c == 0 || c == 2)) ? 24'h0000FF : 24'h111111, acc + 1 + r * 4 + c);
        push(0, 1, 0, 24'h0, acc + 49);
        drain();

        // Reset in the middle of a 6x6 fill
        issue(2'd0, 0, 0, 6, 6, 24'hABCDEF, 24'h0, 128'd0, 1'b0, acc);
        for (int k = 0; k < 4; k++) push(0, 0, k, 24'hABCDEF, acc + 1 + k);
        n = 0;
        while (cyc != acc + 4 && n < 50) begin @(negedge clk); n++; end
        sys_rst_n = 1'b0;
        cmd_op = 2'd0; cmd_x = 11'd7; cmd_y = 11'd7; cmd_w = 11'd2; cmd_h = 11'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_ena", int'(fb_ena), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", int'(cmd_ready), 1);
        issue(2'd0, 1, 1, 2, 1, 24'h0F0F0F, 24'h0, 128'd0, 1'b0, acc);
        push(0, 0, 481, 24'h0F0F0F, acc + 1);
        push(0, 0, 482, 24'h0F0F0F, acc + 2);
        push(0, 1, 0, 24'h0, acc + 3);
        drain();

        // Small panel: full clear with a second command held valid behind it
        @(negedge clk);
        s_cmd_op = 2'd2; s_cmd_bg = 24'h00FF00; s_cmd_fg = 24'h777777; s_cmd_valid = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        for (int k = 0; k < 200; k++) push(1, 0, k, 24'h00FF00, acc + 1 + k);
        push(1, 1, 0, 24'h0, acc + 201);
        s_cmd_op = 2'd0; s_cmd_x = 11'd18; s_cmd_y = 11'd9; s_cmd_w = 11'd4; s_cmd_h = 11'd3;
        s_cmd_fg = 24'hC0FFEE;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_cmd_ready || n >= 1000) break;
            n++;
        end
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
        acc2 = cyc;
        chk("held_accept_cyc", acc2, acc + 203);
        push(1, 0, 198, 24'hC0FFEE, acc2 + 1);
        push(1, 0, 199, 24'hC0FFEE, acc2 + 2);
        push(1, 1, 0, 24'h0, acc2 + 3);
        drain();

        repeat (3) @(negedge clk);
        chk("queues_empty", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_blit_writer.md
Name: fb_blit_writer

Overview:
- Drawing engine that produces the framebuffer write-port traffic (fb_ena/fb_wea/fb_addra/fb_dina) consumed by the LCD display path.
- Accepts one drawing command at a time over a valid/ready handshake: rectangle fill, 8x16 character glyph, or full-screen clear.
- Emits one pixel write per clock in raster order, clipped to the panel area.
- Sits between the host or control logic and the LCD character/picture display top.

Parameters:
H_DISP, 480, horizontal resolution in pixels; row pitch of the framebuffer
V_DISP, 272, vertical resolution in lines
ADDR_W, 17, framebuffer address width; H_DISP*V_DISP must be at most 2^ADDR_W

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle, can accept a command
cmd_op  in  2  0 = fill, 1 = glyph, 2 = clear, 3 = no-op
cmd_x  in  11  left pixel column
cmd_y  in  11  top pixel row
cmd_w  in  11  fill width; ignored for glyph and clear
cmd_h  in  11  fill height; ignored for glyph and clear
cmd_fg  in  24  fill colour or glyph foreground colour, RGB888
cmd_bg  in  24  glyph background colour or clear colour
cmd_glyph  in  128  8x16 bitmap; bit 127 is the top-left pixel, row-major, MSB first
cmd_transp  in  1  glyph: skip writes for 0-bits
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
fb_ena  out  1  framebuffer port enable
fb_wea  out  1  framebuffer write enable
fb_addra  out  ADDR_W  pixel address = y*H_DISP + x
fb_dina  out  24  pixel data

Behaviour:
- Reset (sys_rst_n low at a clock edge) has priority over everything else.
  - Effects: state goes to IDLE; fb_ena, fb_wea, fb_addra, fb_dina, busy and done all go to 0.
  - Commands presented during reset are ignored.
  - Reset during a command aborts it; pixels already written stay written; no done pulse is produced.
- cmd_ready = (state == IDLE). A command is accepted on the edge where cmd_valid && cmd_ready, and all cmd_* fields are captured on that edge.
- State machine: IDLE -> SETUP -> WRITE -> DONE -> IDLE.
  - SETUP (1 cycle): computes the clipped extents and the registered start address y*H_DISP + x. This is the only multiply.
  - WRITE: one pixel per cycle; x runs fastest. Row advance does base += H_DISP, incrementally.
  - DONE (1 cycle): done = 1; returns to IDLE on the next edge.
- busy is 1 from the cycle after acceptance through the DONE cycle inclusive.
- Clipping:
  - w_eff = 0 if x >= H_DISP, else min(w, H_DISP - x).
  - h_eff uses the same rule with y and V_DISP.
  - Glyph uses w = 8, h = 16 before clipping. Clear uses x = 0, y = 0, w = H_DISP, h = V_DISP.
  - If w_eff or h_eff is 0, SETUP goes directly to DONE with no writes.
- Op 3 (no-op): accepted, performs no writes, passes through SETUP and DONE.
- Write cycles:
  - fb_ena = fb_wea = 1, fb_addra = current address, fb_dina = colour; all registered.
  - First write is visible in the cycle after SETUP. Total latency from acceptance edge to done = 2 + w_eff*h_eff cycles.
  - Fill: colour = cmd_fg. Clear: colour = cmd_bg.
  - Glyph: the pixel at row r, column c uses bit 127 - (8r + c); bit 1 selects fg.
  - Glyph bit 0 selects bg when cmd_transp = 0. When cmd_transp = 1, that cycle is still consumed but fb_ena = fb_wea = 0.
- Outside write cycles: fb_ena = fb_wea = 0; fb_addra and fb_dina hold their last values.
- Arithmetic: the address counter is ADDR_W bits with no wrap, since clipping guarantees address < H_DISP*V_DISP. Extent counters are 11 bits.

Test Plan:
- Fill x=10, y=2, w=3, h=2, fg=FF0000 -> writes addresses 970, 971, 972, 1450, 1451, 1452 with data FF0000 on 6 consecutive cycles; done 8 cycles after acceptance; cmd_ready low throughout.
- Clip: fill x=478, y=271, w=5, h=5 -> exactly 2 writes (130558, 130559); x=480 or w=0 -> no writes, done 2 cycles after acceptance.
- Glyph x=0, y=0, bitmap 0x80 followed by zeros, fg=FFFFFF, bg=000000, transp=0 -> 128 write cycles; address 0 gets FFFFFF; address 1 gets 000000; last address 15*480+7 = 7207.
- Same glyph with transp=1 -> exactly 1 cycle with fb_ena=1 (address 0); 128 write-phase cycles total; done at cycle 130.
- Clear with bg=00FF00 -> 130560 consecutive writes, addresses 0..130559, then done; a cmd_valid held during the clear is not accepted until cmd_ready returns.
- Reset asserted 5 cycles into a 6x6 fill -> next edge: fb_ena=0, busy=0, no done; cmd_ready=1 after release; a new command is accepted normally.
